// File: rtl/io_input_ctrl.sv
// io_input_ctrl
// Sequencing controller for the memory-mapped input port bank.
// - Synchronizes two raw 32-bit input ports.
// - Samples them on a programmable prescaler tick.
// - Debounces each port as a whole word and flags changes.
// - Serves CPU reads through a registered req/ack handshake.
//
// Ports:
//   io_clk        clock, all state on the rising edge
//   reset         asynchronous active-high reset
//   addr          byte address, addr[7:2] selects the register
//   rd_req        read request, sampled in IDLE
//   rd_ack        one-cycle pulse, io_read_data valid this cycle
//   io_read_data  read data, held until the next ack
//   wr_req        single-cycle write strobe (CFG only, no ack)
//   wr_data       write data
//   in_port0/1    raw input ports, asynchronous to io_clk
//   irq           level interrupt, |(chg & ien), registered
module io_input_ctrl #(
  parameter logic [15:0] DIV_DEFAULT = 16'd1000,
  parameter logic [3:0]  DEB_DEFAULT = 4'd3
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [31:0] io_read_data,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic        irq
);

  localparam logic [5:0] REG_STABLE0 = 6'h30;
  localparam logic [5:0] REG_STABLE1 = 6'h31;
  localparam logic [5:0] REG_STATUS  = 6'h32;
  localparam logic [5:0] REG_CFG     = 6'h33;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rd_state_t;

  // Result of one debounce evaluation for a single port.
  typedef struct packed {
    logic [31:0] samp;
    logic [3:0]  dcnt;
    logic [31:0] stable;
    logic        set;
  } deb_t;

  // One tick of the word debouncer. dcnt counts equal samples after the
  // change sample, so the stable value updates on the deb-th equal tick.
  function automatic deb_t deb_step(input logic [31:0] sync_v,
                                    input logic [31:0] samp_v,
                                    input logic [31:0] stable_v,
                                    input logic [3:0]  dcnt_v,
                                    input logic [3:0]  deb_last_v);
    deb_t r;
    r.samp   = samp_v;
    r.dcnt   = dcnt_v;
    r.stable = stable_v;
    r.set    = 1'b0;
    if (sync_v != samp_v) begin
      r.samp = sync_v;
      r.dcnt = 4'd0;
    end else begin
      if (dcnt_v != 4'd15) begin
        r.dcnt = dcnt_v + 4'd1;
      end else begin
        r.dcnt = dcnt_v;
      end
      if ((dcnt_v == deb_last_v) && (samp_v != stable_v)) begin
        r.stable = samp_v;
        r.set    = 1'b1;
      end else begin
        r.stable = stable_v;
      end
    end
    return r;
  endfunction

  logic [31:0] p0_meta_r, p0_sync_r, p1_meta_r, p1_sync_r;
  logic [31:0] samp0_r, samp1_r, stable0_r, stable1_r;
  logic [3:0]  dcnt0_r, dcnt1_r;
  logic [1:0]  chg_r, ien_r;
  logic [15:0] div_r, cnt_r;
  logic [3:0]  deb_r;
  logic [31:0] rd_data_r;
  logic        clr_status_r;
  logic        irq_r;
  rd_state_t   state_r, state_next_s;

  logic        rd_load_s;
  logic        cfg_wr_s;
  logic        tick_s;
  logic [15:0] div_last_s;
  logic [3:0]  deb_last_s;
  logic [31:0] rd_mux_s;
  logic [1:0]  chg_set_s, chg_clr_s, chg_next_s;
  deb_t        deb0_s, deb1_s;
  logic        unused_ok_s;

  // Address bits outside the register window and the reserved CFG bits are
  // deliberately ignored.
  assign unused_ok_s = ^{addr[31:8], addr[1:0], wr_data[31:22]};

  assign cfg_wr_s = wr_req && (addr[7:2] == REG_CFG);

  // Prescaler/debounce limits; a programmed 0 behaves like 1.
  always_comb begin
    div_last_s = 16'd0;
    deb_last_s = 4'd0;
    if (div_r == 16'd0) begin
      div_last_s = 16'd0;
    end else begin
      div_last_s = div_r - 16'd1;
    end
    if (deb_r == 4'd0) begin
      deb_last_s = 4'd0;
    end else begin
      deb_last_s = deb_r - 4'd1;
    end
  end

  assign tick_s = (cnt_r == div_last_s);

  // Per-port debounce evaluation.
  always_comb begin
    deb0_s = deb_step(p0_sync_r, samp0_r, stable0_r, dcnt0_r, deb_last_s);
    deb1_s = deb_step(p1_sync_r, samp1_r, stable1_r, dcnt1_r, deb_last_s);
  end

  // Read-FSM next state; a request is only accepted in IDLE.
  always_comb begin
    state_next_s = state_r;
    rd_load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_req) begin
          state_next_s = ST_ACK;
          rd_load_s    = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
          rd_load_s    = 1'b0;
        end
      end
      ST_ACK: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Register read decode.
  always_comb begin
    rd_mux_s = 32'd0;
    case (addr[7:2])
      REG_STABLE0: rd_mux_s = stable0_r;
      REG_STABLE1: rd_mux_s = stable1_r;
      REG_STATUS:  rd_mux_s = {30'd0, chg_r};
      REG_CFG:     rd_mux_s = {10'd0, ien_r, deb_r, div_r};
      default:     rd_mux_s = 32'd0;
    endcase
  end

  // Change flags: STATUS read clears what it captured, a new event wins.
  always_comb begin
    chg_set_s = 2'b00;
    chg_clr_s = 2'b00;
    if (tick_s) begin
      chg_set_s = {deb1_s.set, deb0_s.set};
    end else begin
      chg_set_s = 2'b00;
    end
    if ((state_r == ST_ACK) && clr_status_r) begin
      chg_clr_s = rd_data_r[1:0];
    end else begin
      chg_clr_s = 2'b00;
    end
    chg_next_s = (chg_r & ~chg_clr_s) | chg_set_s;
  end

  // Two-flop synchronizers on the raw ports.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      p0_meta_r <= 32'd0;
      p0_sync_r <= 32'd0;
      p1_meta_r <= 32'd0;
      p1_sync_r <= 32'd0;
    end else begin
      p0_meta_r <= in_port0;
      p0_sync_r <= p0_meta_r;
      p1_meta_r <= in_port1;
      p1_sync_r <= p1_meta_r;
    end
  end

  // Prescaler counter, restarted by any CFG write.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      cnt_r <= 16'd0;
    end else if (cfg_wr_s || tick_s) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  // CFG register.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      div_r <= DIV_DEFAULT;
      deb_r <= DEB_DEFAULT;
      ien_r <= 2'b00;
    end else if (cfg_wr_s) begin
      div_r <= wr_data[15:0];
      deb_r <= wr_data[19:16];
      ien_r <= wr_data[21:20];
    end
  end

  // Debounce state, advanced only on prescaler ticks.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      samp0_r   <= 32'd0;
      samp1_r   <= 32'd0;
      stable0_r <= 32'd0;
      stable1_r <= 32'd0;
      dcnt0_r   <= 4'd0;
      dcnt1_r   <= 4'd0;
    end else if (tick_s) begin
      samp0_r   <= deb0_s.samp;
      samp1_r   <= deb1_s.samp;
      stable0_r <= deb0_s.stable;
      stable1_r <= deb1_s.stable;
      dcnt0_r   <= deb0_s.dcnt;
      dcnt1_r   <= deb1_s.dcnt;
    end
  end

  // Change flags and registered interrupt.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      chg_r <= 2'b00;
      irq_r <= 1'b0;
    end else begin
      chg_r <= chg_next_s;
      irq_r <= |(chg_r & ien_r);
    end
  end

  // Read FSM state register.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Read data capture; remembers whether the captured word was STATUS.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      rd_data_r    <= 32'd0;
      clr_status_r <= 1'b0;
    end else begin
      clr_status_r <= rd_load_s && (addr[7:2] == REG_STATUS);
      if (rd_load_s) begin
        rd_data_r <= rd_mux_s;
      end
    end
  end

  assign rd_ack       = (state_r == ST_ACK);
  assign io_read_data = rd_data_r;
  assign irq          = irq_r;

endmodule
